// File: rtl/mips_execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU, multi-cycle
// multiply/divide unit with HI/LO, E-stage exception detection and local register decode.
module mips_execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        IntExcReq,
    input  logic [31:0] Instr,
    input  logic [31:0] GRFRData1,
    input  logic [31:0] GRFRData2,
    input  logic [31:0] Imm,
    input  logic [31:0] M_EResult,
    input  logic [31:0] W_GRFWData,
    input  logic [1:0]  Trans_ALUIn_Sel1,
    input  logic [1:0]  Trans_ALUIn_Sel2,
    output logic [31:0] RData1,
    output logic [31:0] RData2,
    output logic [31:0] EResult,
    output logic        MDUStart,
    output logic        MDUBusy,
    output logic [4:0]  ReadA1,
    output logic [4:0]  ReadA2,
    output logic [4:0]  WriteA,
    input  logic [4:0]  ExcCodePrev,
    output logic [4:0]  ExcCode,
    output logic        isERET
);
    localparam logic [31:0] EretWord = 32'h42000018;
    localparam logic [4:0]  ExcOv    = 5'd12;
    localparam logic [4:0]  ExcAdEL  = 5'd4;
    localparam logic [4:0]  ExcAdES  = 5'd5;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, shamt;
    assign op    = Instr[31:26];
    assign rs    = Instr[25:21];
    assign rt    = Instr[20:16];
    assign rd    = Instr[15:11];
    assign shamt = Instr[10:6];
    assign funct = Instr[5:0];

    logic        use_imm, is_load, is_store, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic [31:0] alu_b, alu_res, sum, diff;
    logic        sum_ovf, diff_ovf, ovf, addr_ovf;

    // MDU state
    logic [31:0] hi_q, lo_q, a_q, b_q;
    logic [1:0]  mop_q;   // {is_div, is_unsigned}
    logic [3:0]  cnt_q;
    logic        mdu_go;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    // Forwarding muxes for both register operands
    always_comb begin
        case (Trans_ALUIn_Sel1)
            2'd0:    RData1 = GRFRData1;
            2'd1:    RData1 = M_EResult;
            2'd2:    RData1 = W_GRFWData;
            default: RData1 = '0;
        endcase
        case (Trans_ALUIn_Sel2)
            2'd0:    RData2 = GRFRData2;
            2'd1:    RData2 = M_EResult;
            2'd2:    RData2 = W_GRFWData;
            default: RData2 = '0;
        endcase
    end

    // Local decode: register addresses and instruction class flags
    always_comb begin
        ReadA1 = '0;  ReadA2 = '0;  WriteA = '0;
        MDUStart = 1'b0; is_load = 1'b0; is_store = 1'b0;
        is_mfhi = 1'b0;  is_mflo = 1'b0; is_mthi = 1'b0; is_mtlo = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03: begin ReadA2 = rt; WriteA = rd; end
                    6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        ReadA1 = rs; ReadA2 = rt; WriteA = rd;
                    end
                    6'h08: ReadA1 = rs;
                    6'h09: begin ReadA1 = rs; WriteA = rd; end
                    6'h10: begin is_mfhi = 1'b1; WriteA = rd; end
                    6'h12: begin is_mflo = 1'b1; WriteA = rd; end
                    6'h11: begin is_mthi = 1'b1; ReadA1 = rs; end
                    6'h13: begin is_mtlo = 1'b1; ReadA1 = rs; end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin MDUStart = 1'b1; ReadA1 = rs; ReadA2 = rt; end
                    default: ;
                endcase
            end
            6'h01, 6'h06, 6'h07: ReadA1 = rs;
            6'h03: WriteA = 5'd31;
            6'h04, 6'h05: begin ReadA1 = rs; ReadA2 = rt; end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin ReadA1 = rs; WriteA = rt; end
            6'h0f: WriteA = rt;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin is_load = 1'b1; ReadA1 = rs; WriteA = rt; end
            6'h28, 6'h29, 6'h2b: begin is_store = 1'b1; ReadA1 = rs; ReadA2 = rt; end
            default: ;
        endcase
    end

    assign use_imm  = (op[5:3] == 3'b001) || is_load || is_store;
    assign alu_b    = use_imm ? Imm : RData2;
    assign sum      = RData1 + alu_b;
    assign diff     = RData1 - alu_b;
    assign sum_ovf  = (RData1[31] == alu_b[31]) && (sum[31] != RData1[31]);
    assign diff_ovf = (RData1[31] != alu_b[31]) && (diff[31] != RData1[31]);

    // ALU result and overflow detection
    always_comb begin
        alu_res  = '0;
        ovf      = 1'b0;
        addr_ovf = 1'b0;
        if (is_load || is_store) begin
            alu_res  = sum;
            addr_ovf = sum_ovf;
        end else begin
            case (op)
                6'h00: begin
                    case (funct)
                        6'h00: alu_res = RData2 << shamt;
                        6'h02: alu_res = RData2 >> shamt;
                        6'h03: alu_res = $signed(RData2) >>> shamt;
                        6'h04: alu_res = RData2 << RData1[4:0];
                        6'h06: alu_res = RData2 >> RData1[4:0];
                        6'h07: alu_res = $signed(RData2) >>> RData1[4:0];
                        6'h20: begin alu_res = sum; ovf = sum_ovf; end
                        6'h21: alu_res = sum;
                        6'h22: begin alu_res = diff; ovf = diff_ovf; end
                        6'h23: alu_res = diff;
                        6'h24: alu_res = RData1 & alu_b;
                        6'h25: alu_res = RData1 | alu_b;
                        6'h26: alu_res = RData1 ^ alu_b;
                        6'h27: alu_res = ~(RData1 | alu_b);
                        6'h2a: alu_res = {31'b0, $signed(RData1) < $signed(alu_b)};
                        6'h2b: alu_res = {31'b0, RData1 < alu_b};
                        default: ;
                    endcase
                end
                6'h08: begin alu_res = sum; ovf = sum_ovf; end
                6'h09: alu_res = sum;
                6'h0a: alu_res = {31'b0, $signed(RData1) < $signed(alu_b)};
                6'h0b: alu_res = {31'b0, RData1 < alu_b};
                6'h0c: alu_res = RData1 & alu_b;
                6'h0d: alu_res = RData1 | alu_b;
                6'h0e: alu_res = RData1 ^ alu_b;
                6'h0f: alu_res = {alu_b[15:0], 16'b0};
                default: ;
            endcase
        end
    end

    assign EResult = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
    assign isERET  = (Instr == EretWord);

    // Earliest stage wins; otherwise report E-stage faults
    always_comb begin
        if (ExcCodePrev != 5'd0)      ExcCode = ExcCodePrev;
        else if (ovf)                 ExcCode = ExcOv;
        else if (addr_ovf && is_load) ExcCode = ExcAdEL;
        else if (addr_ovf)            ExcCode = ExcAdES;
        else                          ExcCode = 5'd0;
    end

    assign MDUBusy = (cnt_q != 4'd0);
    assign mdu_go  = MDUStart && !MDUBusy && !IntExcReq;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign quo_s  = $signed(a_q) / $signed(b_q);
    assign rem_s  = $signed(a_q) % $signed(b_q);
    assign quo_u  = a_q / b_q;
    assign rem_u  = a_q % b_q;

    // MDU sequencing: latch operands on start, write HI/LO on the last busy cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            mop_q <= '0;
            cnt_q <= '0;
        end else begin
            if (mdu_go) begin
                a_q   <= RData1;
                b_q   <= RData2;
                mop_q <= funct[1:0];
                cnt_q <= funct[1] ? 4'd10 : 4'd5;
            end else if (MDUBusy) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!mop_q[1]) begin
                        {hi_q, lo_q} <= mop_q[0] ? prod_u : prod_s;
                    end else if (b_q != 32'd0) begin
                        lo_q <= mop_q[0] ? quo_u : quo_s;
                        hi_q <= mop_q[0] ? rem_u : rem_s;
                    end
                end
            end
            if (is_mthi && !IntExcReq) hi_q <= RData1;
            if (is_mtlo && !IntExcReq) lo_q <= RData1;
        end
    end
endmodule

// File: tb/tb_mips_execute_stage.sv
// Directed self-checking bench for mips_execute_stage.
module tb_mips_execute_stage;
    logic        clk = 1'b0;
    logic        reset, IntExcReq;
    logic [31:0] Instr, GRFRData1, GRFRData2, Imm, M_EResult, W_GRFWData;
    logic [1:0]  Trans_ALUIn_Sel1, Trans_ALUIn_Sel2;
    logic [31:0] RData1, RData2, EResult;
    logic        MDUStart, MDUBusy, isERET;
    logic [4:0]  ReadA1, ReadA2, WriteA, ExcCodePrev, ExcCode;

    int total = 0;
    int bad   = 0;

    mips_execute_stage dut (
        .clk(clk), .reset(reset), .IntExcReq(IntExcReq), .Instr(Instr),
        .GRFRData1(GRFRData1), .GRFRData2(GRFRData2), .Imm(Imm),
        .M_EResult(M_EResult), .W_GRFWData(W_GRFWData),
        .Trans_ALUIn_Sel1(Trans_ALUIn_Sel1), .Trans_ALUIn_Sel2(Trans_ALUIn_Sel2),
        .RData1(RData1), .RData2(RData2), .EResult(EResult),
        .MDUStart(MDUStart), .MDUBusy(MDUBusy),
        .ReadA1(ReadA1), .ReadA2(ReadA2), .WriteA(WriteA),
        .ExcCodePrev(ExcCodePrev), .ExcCode(ExcCode), .isERET(isERET)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] Nop  = 32'h0;
    localparam logic [31:0] Mfhi = {6'h0, 10'h0, 5'd4, 5'd0, 6'h10};
    localparam logic [31:0] Mflo = {6'h0, 10'h0, 5'd4, 5'd0, 6'h12};

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    // Sample busy across an MDU operation that starts at the next edge, then expect it low
    task run_mdu(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            Instr = Nop;
            check(tag, {31'b0, MDUBusy}, 32'd1);
        end
        tick();
        check(tag, {31'b0, MDUBusy}, 32'd0);
    endtask

    task check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        Instr = Mfhi; #1;
        check({tag, "_hi"}, EResult, hi);
        Instr = Mflo; #1;
        check({tag, "_lo"}, EResult, lo);
        Instr = Nop;
    endtask

    initial begin
        reset = 1'b1; IntExcReq = 1'b0; Instr = Nop;
        GRFRData1 = '0; GRFRData2 = '0; Imm = '0; M_EResult = '0; W_GRFWData = '0;
        Trans_ALUIn_Sel1 = 2'd0; Trans_ALUIn_Sel2 = 2'd0; ExcCodePrev = '0;
        tick(); tick();
        check("reset_busy", {31'b0, MDUBusy}, 32'd0);
        reset = 1'b0;
        check_hilo("reset", 32'h0, 32'h0);

        // add overflow and exception pass-through
        Instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        GRFRData1 = 32'h7FFFFFFF; GRFRData2 = 32'h1; #1;
        check("add_res", EResult, 32'h80000000);
        check("add_ov", {27'b0, ExcCode}, 32'd12);
        check("add_ra1", {27'b0, ReadA1}, 32'd1);
        check("add_ra2", {27'b0, ReadA2}, 32'd2);
        check("add_wa", {27'b0, WriteA}, 32'd3);
        check("add_eret", {31'b0, isERET}, 32'd0);
        ExcCodePrev = 5'd10; #1;
        check("exc_prev", {27'b0, ExcCode}, 32'd10);
        ExcCodePrev = 5'd0;
        Instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); #1;
        check("addu_noov", {27'b0, ExcCode}, 32'd0);

        // forwarding
        Instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h23);
        Trans_ALUIn_Sel1 = 2'd1; M_EResult = 32'd5;
        Trans_ALUIn_Sel2 = 2'd2; W_GRFWData = 32'd3; #1;
        check("fwd_rd1", RData1, 32'd5);
        check("fwd_rd2", RData2, 32'd3);
        check("subu_res", EResult, 32'd2);
        Trans_ALUIn_Sel1 = 2'd3; #1;
        check("fwd_zero", RData1, 32'd0);
        check("subu_neg", EResult, 32'hFFFFFFFD);
        Trans_ALUIn_Sel1 = 2'd0; Trans_ALUIn_Sel2 = 2'd0;

        // other ALU ops
        GRFRData1 = 32'hFFFFFFFF; GRFRData2 = 32'd1;
        Instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2a); #1;
        check("slt", EResult, 32'd1);
        Instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2b); #1;
        check("sltu", EResult, 32'd0);
        GRFRData2 = 32'h80000000;
        Instr = rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h03); #1;
        check("sra", EResult, 32'hF8000000);
        Instr = itype(6'h0f, 5'd0, 5'd7, 16'h1234); Imm = 32'h1234; #1;
        check("lui", EResult, 32'h12340000);
        check("lui_wa", {27'b0, WriteA}, 32'd7);

        // decode and address exceptions
        GRFRData1 = 32'h10; Imm = 32'h1;
        Instr = itype(6'h0d, 5'd9, 5'd8, 16'h1); #1;
        check("ori_res", EResult, 32'h11);
        check("ori_ra1", {27'b0, ReadA1}, 32'd9);
        check("ori_ra2", {27'b0, ReadA2}, 32'd0);
        check("ori_wa", {27'b0, WriteA}, 32'd8);
        Instr = {6'h03, 26'h40}; #1;
        check("jal_wa", {27'b0, WriteA}, 32'd31);
        Instr = itype(6'h2b, 5'd3, 5'd2, 16'h0); #1;
        check("sw_ra1", {27'b0, ReadA1}, 32'd3);
        check("sw_ra2", {27'b0, ReadA2}, 32'd2);
        check("sw_wa", {27'b0, WriteA}, 32'd0);
        GRFRData1 = 32'h7FFFFFFF; #1;
        check("sw_ades", {27'b0, ExcCode}, 32'd5);
        Instr = itype(6'h23, 5'd3, 5'd2, 16'h1); #1;
        check("lw_adel", {27'b0, ExcCode}, 32'd4);
        Instr = 32'h42000018; #1;
        check("eret", {31'b0, isERET}, 32'd1);
        Instr = Nop;

        // signed multiply
        GRFRData1 = 32'hFFFFFFFE; GRFRData2 = 32'd3;
        Instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18); #1;
        check("mult_start", {31'b0, MDUStart}, 32'd1);
        check("mult_idle", {31'b0, MDUBusy}, 32'd0);
        run_mdu("mult_busy", 5);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        // unsigned divide, divide by zero, signed divide
        GRFRData1 = 32'd7; GRFRData2 = 32'd2;
        Instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1b); #1;
        run_mdu("divu_busy", 10);
        check_hilo("divu", 32'd1, 32'd3);
        GRFRData1 = 32'd5; GRFRData2 = 32'd0;
        Instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1b); #1;
        run_mdu("div0_busy", 10);
        check_hilo("div0", 32'd1, 32'd3);
        GRFRData1 = 32'hFFFFFFF9; GRFRData2 = 32'd2;
        Instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1a); #1;
        run_mdu("div_busy", 10);
        check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // reset in the middle of a divide
        GRFRData1 = 32'd7; GRFRData2 = 32'd2;
        Instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1b); #1;
        tick(); Instr = Nop; tick(); tick();
        check("mid_busy", {31'b0, MDUBusy}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_busy", {31'b0, MDUBusy}, 32'd0);
        check_hilo("rst", 32'd0, 32'd0);

        // mthi/mtlo, then IntExcReq suppression
        GRFRData1 = 32'h1234; Instr = rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h11); tick();
        GRFRData1 = 32'h5678; Instr = rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h13); tick();
        check_hilo("mt", 32'h1234, 32'h5678);
        IntExcReq = 1'b1;
        GRFRData1 = 32'd5; GRFRData2 = 32'd6;
        Instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18); tick(); tick();
        check("intexc_busy", {31'b0, MDUBusy}, 32'd0);
        GRFRData1 = 32'hDEAD; Instr = rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h11); tick();
        Instr = Nop; tick(); tick(); tick(); tick(); tick();
        IntExcReq = 1'b0;
        check_hilo("intexc", 32'h1234, 32'h5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_execute_stage.md
Name: mips_execute_stage

Overview:
Execute (E) stage datapath of the 5-stage MIPS pipeline. It contains:
- forwarding muxes for both register operands;
- the ALU and a multi-cycle multiply/divide unit (MDU) with HI/LO registers;
- E-stage exception detection;
- local instruction decode for the register addresses read/written by the instruction currently in E.

All outputs are combinational except MDU state (HI, LO, busy counter).

Parameters:
none

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
IntExcReq  in  1  interrupt/exception being taken this cycle; suppresses MDU start and HI/LO writes
Instr  in  32  instruction in E
GRFRData1  in  32  rs value from D/E register
GRFRData2  in  32  rt value from D/E register
Imm  in  32  immediate, already sign/zero-extended by decode
M_EResult  in  32  forwarded result from M stage
W_GRFWData  in  32  forwarded write data from W stage
Trans_ALUIn_Sel1  in  2  operand-1 source: 0 GRFRData1, 1 M_EResult, 2 W_GRFWData, 3 zero
Trans_ALUIn_Sel2  in  2  operand-2 source, same encoding
RData1  out  32  forwarded rs value
RData2  out  32  forwarded rt value (store data)
EResult  out  32  ALU result, or HI/LO for mfhi/mflo
MDUStart  out  1  Instr is mult/multu/div/divu
MDUBusy  out  1  MDU computing
ReadA1  out  5  rs if the instruction reads rs, else 0
ReadA2  out  5  rt if the instruction reads rt, else 0
WriteA  out  5  destination register, 0 if none
ExcCodePrev  in  5  exception code from earlier stages, 0 = none
ExcCode  out  5  exception code leaving E
isERET  out  1  Instr == 32'h42000018

Behaviour:
Forwarding:
- RData1 and RData2 are the selected forwarding-mux outputs.
- ALU A = RData1. ALU B = Imm for I-type ALU instructions and loads/stores, else RData2.

ALU:
- Shift amount = Instr[10:6] for sll/srl/sra; RData1[4:0] for sllv/srlv/srav.
- add/addi/addu/addiu/loads/stores compute A+B.
- sub/subu compute A-B.
- and/andi, or/ori, xor/xori, nor are bitwise.
- slt/slti compare signed; sltu/sltiu compare unsigned; result is 1 or 0.
- lui = Imm<<16.
- Overflow is signed 32-bit overflow of add/addi/sub, and of the address add for loads/stores.
- Undefined or other instructions give result 0.

EResult:
- mfhi returns HI; mflo returns LO.
- All other instructions return the ALU result.

MDU:
- Starts when MDUStart=1, MDUBusy=0 and IntExcReq=0.
- Start latches the operands; HI/LO are updated at completion.
- mult/multu: {HI,LO} = 64-bit product, signed or unsigned respectively.
- div/divu: LO = quotient, HI = remainder, signed or unsigned respectively.
- Divide by zero leaves HI/LO unchanged.
- MDUBusy rises the cycle after start and stays high for 5 cycles (mult) or 10 cycles (div). Results are visible the cycle busy falls.
- mthi/mtlo write RData1 to HI/LO at the clock edge unless IntExcReq=1.
- IntExcReq has no effect on an operation already running.
- reset clears HI, LO, busy and the counter, including mid-operation.

Exceptions:
- If ExcCodePrev != 0 it passes through unchanged (earliest stage wins).
- Otherwise ExcCode = 12 (Ov) on add/addi/sub overflow, 4 (AdEL) on load address overflow, 5 (AdES) on store address overflow, else 0.

Write address (WriteA):
- rd for R-type ALU instructions, shifts, mfhi, mflo and jalr.
- rt for I-type ALU instructions, lui and loads.
- 31 for jal.
- 0 otherwise, including mult/div, mthi/mtlo, stores, branches, eret and nop.

Read addresses:
- ReadA1 = rs for all instructions using rs (ALU, loads, stores, branches, jr, jalr, mult/div, mthi, mtlo).
- ReadA2 = rt for R-type ALU instructions, shifts, stores, beq/bne and mult/div.
- Both are 0 otherwise.

Test Plan:
- add with GRFRData1=32'h7FFFFFFF, GRFRData2=1, both selects=0 -> EResult=32'h80000000, ExcCode=12. Repeat with ExcCodePrev=10 -> ExcCode=10.
- Forwarding: Sel1=1 with M_EResult=5, Sel2=2 with W_GRFWData=3, subu -> RData1=5, RData2=3, EResult=2. Set Sel1=3 -> RData1=0.
- mult with RData1=-2, RData2=3 -> MDUStart=1, busy high for 5 cycles; then mflo=32'hFFFFFFFA, mfhi=32'hFFFFFFFF.
- divu 7/2 -> busy high for 10 cycles, then LO=3, HI=1. Assert reset mid-div -> busy=0, HI=LO=0 next cycle.
- mult with IntExcReq=1 -> MDUBusy stays 0, HI/LO unchanged. mthi with IntExcReq=1 -> HI unchanged.
- Decode checks:
  - ori $8,$9,0x1 -> ReadA1=9, ReadA2=0, WriteA=8.
  - jal -> WriteA=31.
  - sw $2,0($3) -> ReadA1=3, ReadA2=2, WriteA=0.
  - 32'h42000018 -> isERET=1.
